// File: rtl/wb_commit_stage_pkg.sv
// Shared constants and trace-record layout for the writeback/commit stage.
package wb_commit_stage_pkg;

    localparam int XLEN      = 32;
    localparam int RADDR_W   = 5;
    localparam int CSR_NUM_W = 14;
    localparam int ECODE_W   = 6;
    localparam int ESUB_W    = 9;

    // Retired-instruction trace record, MSB first: {pc, we, waddr, wdata}.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [XLEN-1:0]    wdata;
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

    // Record width for a non-default datapath; same field order as trace_rec_t.
    function automatic int trace_rec_w(input int xlen, input int raddr_w);
        return 2 * xlen + raddr_w + 1;
    endfunction

endpackage

// File: rtl/wb_commit_stage_trace_fifo.sv
// Synchronous FIFO holding retired-instruction trace records.
// Head data is read straight from storage, so a pushed entry becomes
// visible the cycle after it is written. DEPTH must be a power of two.
module wb_commit_stage_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Occupancy flags and head read.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        head_data = mem_q[rd_ptr_q];
    end

    // Next-state: storage write, pointer advance (wraps naturally), count.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~empty;
        // A push into a full FIFO is only legal when the head leaves this cycle.
        do_push  = push & (~full | do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is cleared too, so the head reads 0 after reset rather than stale data.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: one-entry pipeline register with valid/allowin
// handshake, regfile/CSR commit strobes, exception/ertn flush, and a trace
// FIFO whose fullness back-pressures MEM.
module wb_commit_stage #(
    parameter int XLEN        = wb_commit_stage_pkg::XLEN,
    parameter int RADDR_W     = wb_commit_stage_pkg::RADDR_W,
    parameter int CSR_NUM_W   = wb_commit_stage_pkg::CSR_NUM_W,
    parameter int ECODE_W     = wb_commit_stage_pkg::ECODE_W,
    parameter int ESUB_W      = wb_commit_stage_pkg::ESUB_W,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    // MEM -> WB
    input  logic                 mem_valid,
    output logic                 wb_allowin,
    input  logic [XLEN-1:0]      mem_pc,
    input  logic                 mem_gr_we,
    input  logic [RADDR_W-1:0]   mem_dest,
    input  logic [XLEN-1:0]      mem_result,
    input  logic                 mem_csr_re,
    input  logic                 mem_csr_we,
    input  logic [CSR_NUM_W-1:0] mem_csr_num,
    input  logic [XLEN-1:0]      mem_csr_wmask,
    input  logic [XLEN-1:0]      mem_csr_wvalue,
    input  logic                 mem_ex,
    input  logic [ECODE_W-1:0]   mem_ecode,
    input  logic [ESUB_W-1:0]    mem_esubcode,
    input  logic                 mem_ertn,
    // CSR port
    output logic                 csr_re,
    output logic [CSR_NUM_W-1:0] csr_num,
    input  logic [XLEN-1:0]      csr_rvalue,
    output logic                 csr_we,
    output logic [XLEN-1:0]      csr_wmask,
    output logic [XLEN-1:0]      csr_wvalue,
    // Exception / ertn
    output logic                 wb_ex,
    output logic                 ertn_flush,
    output logic [XLEN-1:0]      wb_pc,
    output logic [ECODE_W-1:0]   wb_ecode,
    output logic [ESUB_W-1:0]    wb_esubcode,
    // Regfile write port
    output logic                 rf_we,
    output logic [RADDR_W-1:0]   rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    // Debug trace port
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [XLEN-1:0]      trace_pc,
    output logic [3:0]           trace_we,
    output logic [RADDR_W-1:0]   trace_waddr,
    output logic [XLEN-1:0]      trace_wdata
);

    import wb_commit_stage_pkg::*;

    localparam int TREC_W = trace_rec_w(XLEN, RADDR_W);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic                 gr_we;
        logic [RADDR_W-1:0]   dest;
        logic [XLEN-1:0]      result;
        logic                 csr_re;
        logic                 csr_we;
        logic [CSR_NUM_W-1:0] csr_num;
        logic [XLEN-1:0]      csr_wmask;
        logic [XLEN-1:0]      csr_wvalue;
        logic                 ex;
        logic [ECODE_W-1:0]   ecode;
        logic [ESUB_W-1:0]    esubcode;
        logic                 ertn;
    } wb_payload_t;

    logic        wb_valid_q, wb_valid_d;
    wb_payload_t payload_q, payload_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_can_push;
    logic              fifo_push;
    logic              fifo_pop;
    logic [TREC_W-1:0] fifo_push_data;
    logic [TREC_W-1:0] fifo_head;

    logic ready_go;
    logic commit;
    logic load;
    logic flush;

    // Handshake and next state of the WB register.
    always_comb begin
        // Exceptions leave no trace record, so they never wait on the FIFO.
        fifo_can_push = ~fifo_full | trace_ready;
        ready_go      = payload_q.ex | fifo_can_push;
        commit        = wb_valid_q & ready_go;
        wb_allowin    = ~wb_valid_q | ready_go;
        load          = mem_valid & wb_allowin;
        flush         = commit & (payload_q.ex | payload_q.ertn);

        wb_valid_d = wb_valid_q;
        payload_d  = payload_q;
        if (flush) begin
            // The younger instruction offered this cycle is squashed.
            wb_valid_d = 1'b0;
        end else if (load) begin
            wb_valid_d           = 1'b1;
            payload_d.pc         = mem_pc;
            payload_d.gr_we      = mem_gr_we;
            payload_d.dest       = mem_dest;
            payload_d.result     = mem_result;
            payload_d.csr_re     = mem_csr_re;
            payload_d.csr_we     = mem_csr_we;
            payload_d.csr_num    = mem_csr_num;
            payload_d.csr_wmask  = mem_csr_wmask;
            payload_d.csr_wvalue = mem_csr_wvalue;
            payload_d.ex         = mem_ex;
            payload_d.ecode      = mem_ecode;
            payload_d.esubcode   = mem_esubcode;
            payload_d.ertn       = mem_ertn;
        end else if (commit) begin
            wb_valid_d = 1'b0;
        end
    end

    // Commit strobes and datapath outputs driven from the WB register.
    always_comb begin
        csr_re      = wb_valid_q & payload_q.csr_re;
        csr_num     = payload_q.csr_num;
        csr_wmask   = payload_q.csr_wmask;
        csr_wvalue  = payload_q.csr_wvalue;
        rf_wdata    = payload_q.csr_re ? csr_rvalue : payload_q.result;
        rf_waddr    = payload_q.dest;
        rf_we       = commit & payload_q.gr_we & ~payload_q.ex;
        csr_we      = commit & payload_q.csr_we & ~payload_q.ex;
        wb_ex       = commit & payload_q.ex;
        ertn_flush  = commit & payload_q.ertn & ~payload_q.ex;
        wb_pc       = payload_q.pc;
        wb_ecode    = payload_q.ecode;
        wb_esubcode = payload_q.esubcode;
    end

    // Trace push/pop and head unpacking (record order {pc, we, waddr, wdata}).
    always_comb begin
        fifo_push      = commit & ~payload_q.ex;
        fifo_push_data = {payload_q.pc, rf_we, payload_q.dest, rf_wdata};
        trace_valid    = ~fifo_empty;
        fifo_pop       = trace_valid & trace_ready;
        trace_pc       = fifo_head[TREC_W-1 -: XLEN];
        trace_we       = {4{fifo_head[XLEN + RADDR_W]}};
        trace_waddr    = fifo_head[XLEN +: RADDR_W];
        trace_wdata    = fifo_head[XLEN-1:0];
    end

    // WB pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            payload_q  <= payload_d;
        end
    end

    wb_commit_stage_trace_fifo #(
        .WIDTH (TREC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model.
module tb_wb_commit_stage;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        ertn;
    } inst_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        wb_allowin;
    logic [31:0] mem_pc = '0;
    logic        mem_gr_we = 1'b0;
    logic [4:0]  mem_dest = '0;
    logic [31:0] mem_result = '0;
    logic        mem_csr_re = 1'b0;
    logic        mem_csr_we = 1'b0;
    logic [13:0] mem_csr_num = '0;
    logic [31:0] mem_csr_wmask = '0;
    logic [31:0] mem_csr_wvalue = '0;
    logic        mem_ex = 1'b0;
    logic [5:0]  mem_ecode = '0;
    logic [8:0]  mem_esubcode = '0;
    logic        mem_ertn = 1'b0;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue = '0;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_pc;
    logic [3:0]  trace_we;
    logic [4:0]  trace_waddr;
    logic [31:0] trace_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    wb_commit_stage #(.TRACE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .wb_allowin(wb_allowin),
        .mem_pc(mem_pc), .mem_gr_we(mem_gr_we), .mem_dest(mem_dest),
        .mem_result(mem_result), .mem_csr_re(mem_csr_re), .mem_csr_we(mem_csr_we),
        .mem_csr_num(mem_csr_num), .mem_csr_wmask(mem_csr_wmask),
        .mem_csr_wvalue(mem_csr_wvalue), .mem_ex(mem_ex), .mem_ecode(mem_ecode),
        .mem_esubcode(mem_esubcode), .mem_ertn(mem_ertn),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_we(trace_we),
        .trace_waddr(trace_waddr), .trace_wdata(trace_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit    m_v = 1'b0;
    inst_t m_slot = '0;
    rec_t  m_q[$];
    bit    nxt_v = 1'b0;
    inst_t nxt_slot = '0;
    rec_t  nxt_q[$];

    // Model state advances on the clock; reset empties it at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v    = 1'b0;
            m_slot = '0;
            m_q.delete();
        end else begin
            m_v    = nxt_v;
            m_slot = nxt_slot;
            m_q    = nxt_q;
        end
    end

    // Compare process: check outputs mid-cycle, then work out the next model state.
    always @(negedge clk) begin : cmp
        bit          can_push, rdy, com, allow;
        logic [31:0] wdata;
        rec_t        r;
        inst_t       offered;

        can_push = (m_q.size() < DEPTH) || trace_ready;
        rdy      = m_slot.ex || can_push;
        com      = m_v && rdy;
        allow    = !m_v || rdy;
        wdata    = m_slot.csr_re ? csr_rvalue : m_slot.result;

        check("wb_allowin", wb_allowin, allow);
        check("rf_we", rf_we, com && m_slot.gr_we && !m_slot.ex);
        check("csr_we", csr_we, com && m_slot.csr_we && !m_slot.ex);
        check("wb_ex", wb_ex, com && m_slot.ex);
        check("ertn_flush", ertn_flush, com && m_slot.ertn && !m_slot.ex);
        check("csr_re", csr_re, m_v && m_slot.csr_re);
        if (m_v) begin
            check("wb_pc", wb_pc, m_slot.pc);
            check("rf_waddr", rf_waddr, m_slot.dest);
            check("rf_wdata", rf_wdata, wdata);
            check("csr_num", csr_num, m_slot.csr_num);
            check("csr_wmask", csr_wmask, m_slot.wmask);
            check("csr_wvalue", csr_wvalue, m_slot.wvalue);
            check("wb_ecode", wb_ecode, m_slot.ecode);
            check("wb_esubcode", wb_esubcode, m_slot.esub);
        end
        check("trace_valid", trace_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("trace_pc", trace_pc, m_q[0].pc);
            check("trace_we", trace_we, {4{m_q[0].we}});
            check("trace_waddr", trace_waddr, m_q[0].waddr);
            check("trace_wdata", trace_wdata, m_q[0].wdata);
        end

        nxt_q = m_q;
        if (m_q.size() > 0 && trace_ready) void'(nxt_q.pop_front());
        if (com && !m_slot.ex) begin
            r.pc    = m_slot.pc;
            r.we    = m_slot.gr_we;
            r.waddr = m_slot.dest;
            r.wdata = wdata;
            nxt_q.push_back(r);
        end

        offered = {mem_pc, mem_gr_we, mem_dest, mem_result, mem_csr_re, mem_csr_we,
                   mem_csr_num, mem_csr_wmask, mem_csr_wvalue, mem_ex, mem_ecode,
                   mem_esubcode, mem_ertn};
        nxt_v    = m_v;
        nxt_slot = m_slot;
        if (com && (m_slot.ex || m_slot.ertn)) begin
            nxt_v = 1'b0;
        end else if (mem_valid && allow) begin
            nxt_v    = 1'b1;
            nxt_slot = offered;
        end else if (com) begin
            nxt_v = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input inst_t i);
        mem_valid      = 1'b1;
        mem_pc         = i.pc;
        mem_gr_we      = i.gr_we;
        mem_dest       = i.dest;
        mem_result     = i.result;
        mem_csr_re     = i.csr_re;
        mem_csr_we     = i.csr_we;
        mem_csr_num    = i.csr_num;
        mem_csr_wmask  = i.wmask;
        mem_csr_wvalue = i.wvalue;
        mem_ex         = i.ex;
        mem_ecode      = i.ecode;
        mem_esubcode   = i.esub;
        mem_ertn       = i.ertn;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
    endtask

    function automatic inst_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] res);
        inst_t i = '0;
        i.pc     = pc;
        i.gr_we  = 1'b1;
        i.dest   = d;
        i.result = res;
        return i;
    endfunction

    task automatic check_quiet_after_reset();
        check("rst_allowin", wb_allowin, 1'b1);
        check("rst_trace_valid", trace_valid, 1'b0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_csr_we", csr_we, 1'b0);
        check("rst_csr_re", csr_re, 1'b0);
        check("rst_wb_ex", wb_ex, 1'b0);
        check("rst_ertn", ertn_flush, 1'b0);
        check("rst_wb_pc", wb_pc, 32'h0);
        check("rst_trace_pc", trace_pc, 32'h0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : stim
        inst_t i;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Asynchronous reset pulse in the middle of a cycle.
        #2 rst = 1'b1;
        #1 check_quiet_after_reset();
        tick();
        rst = 1'b0;
        tick();

        // Plain ALU result into r5.
        trace_ready = 1'b1;
        csr_rvalue  = 32'h0000_ABCD;
        offer(alu(32'h1c00_0000, 5'd5, 32'h1234));
        tick();
        idle();
        mid();
        check("add_rf_we", rf_we, 1'b1);
        check("add_rf_waddr", rf_waddr, 32'd5);
        check("add_rf_wdata", rf_wdata, 32'h1234);
        check("add_trace_not_yet", trace_valid, 1'b0);
        tick();
        mid();
        check("add_trace_valid", trace_valid, 1'b1);
        check("add_trace_pc", trace_pc, 32'h1c00_0000);
        check("add_trace_we", trace_we, 32'hf);
        check("add_trace_wdata", trace_wdata, 32'h1234);
        tick();
        tick();

        // csrrd of CSR 0x6.
        i         = alu(32'h1c00_0004, 5'd7, 32'h0);
        i.csr_re  = 1'b1;
        i.csr_num = 14'h6;
        offer(i);
        tick();
        idle();
        mid();
        check("csrrd_rf_wdata", rf_wdata, 32'hABCD);
        check("csrrd_csr_re", csr_re, 1'b1);
        check("csrrd_csr_num", csr_num, 32'h6);
        tick();
        mid();
        check("csrrd_trace_wdata", trace_wdata, 32'hABCD);
        tick();
        tick();

        // Syscall with a younger instruction offered in the commit cycle.
        i       = alu(32'h1c00_0008, 5'd9, 32'h77);
        i.ex    = 1'b1;
        i.ecode = 6'hB;
        offer(i);
        tick();
        offer(alu(32'h1c00_000c, 5'd6, 32'h66));
        mid();
        check("sys_wb_ex", wb_ex, 1'b1);
        check("sys_rf_we", rf_we, 1'b0);
        check("sys_ecode", wb_ecode, 32'hB);
        tick();
        idle();
        mid();
        check("sys_ex_pulse_once", wb_ex, 1'b0);
        check("sys_dropped_rf_we", rf_we, 1'b0);
        check("sys_no_trace", trace_valid, 1'b0);
        tick();
        tick();

        // Trace FIFO fills, fifth instruction stalls, then commits on trace_ready.
        trace_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            offer(alu(32'h1c00_0100 + 32'(4 * k), 5'(10 + k), 32'h100 + 32'(k)));
            tick();
        end
        offer(alu(32'h1c00_0200, 5'd20, 32'h200));
        for (int k = 0; k < 3; k++) begin
            mid();
            check("stall_allowin", wb_allowin, 1'b0);
            check("stall_rf_we", rf_we, 1'b0);
            check("stall_head_pc", trace_pc, 32'h1c00_0100);
            tick();
        end
        trace_ready = 1'b1;
        mid();
        check("release_rf_we", rf_we, 1'b1);
        check("release_rf_waddr", rf_waddr, 32'd14);
        check("release_allowin", wb_allowin, 1'b1);
        tick();
        idle();
        mid();
        check("release_head_pc", trace_pc, 32'h1c00_0104);
        repeat (8) tick();

        // Reset while stalled with a full FIFO.
        trace_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            offer(alu(32'h1c00_0300 + 32'(4 * k), 5'(k + 1), 32'h300 + 32'(k)));
            tick();
        end
        #2 rst = 1'b1;
        #1 check_quiet_after_reset();
        idle();
        tick();
        rst = 1'b0;
        mid();
        check("post_rst_trace_valid", trace_valid, 1'b0);
        trace_ready = 1'b1;
        tick();

        // ertn that also writes a CSR.
        i         = '0;
        i.pc      = 32'h1c00_0400;
        i.ertn    = 1'b1;
        i.csr_we  = 1'b1;
        i.csr_num = 14'h6;
        i.wmask   = 32'hFFFF_FFFF;
        i.wvalue  = 32'h55;
        offer(i);
        tick();
        idle();
        mid();
        check("ertn_flush", ertn_flush, 1'b1);
        check("ertn_csr_we", csr_we, 1'b1);
        check("ertn_csr_wvalue", csr_wvalue, 32'h55);
        check("ertn_rf_we", rf_we, 1'b0);
        tick();
        mid();
        check("ertn_trace_valid", trace_valid, 1'b1);
        check("ertn_trace_we", trace_we, 32'h0);
        check("ertn_trace_pc", trace_pc, 32'h1c00_0400);
        tick();
        tick();

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst         = 1'b0;
            trace_ready = ($urandom_range(0, 9) < 6);
            csr_rvalue  = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                i         = alu({$urandom_range(0, 32'hFFFF), 2'b00}, 5'($urandom), $urandom);
                i.gr_we   = $urandom_range(0, 3) != 0;
                i.csr_re  = $urandom_range(0, 4) == 0;
                i.csr_we  = $urandom_range(0, 4) == 0;
                i.csr_num = 14'($urandom);
                i.wmask   = $urandom;
                i.wvalue  = $urandom;
                i.ex      = $urandom_range(0, 9) == 0;
                i.ecode   = 6'($urandom);
                i.esub    = 9'($urandom);
                i.ertn    = $urandom_range(0, 19) == 0;
                if (i.ertn) i.gr_we = 1'b0;
                offer(i);
            end else begin
                idle();
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
            end
        end
        tick();
        rst         = 1'b0;
        idle();
        trace_ready = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
Parametrised writeback/commit stage for the LoongArch pipeline and the successor to the fixed-width WB stage. It holds one instruction in its own pipeline register under a valid/allowin handshake. At commit it drives the regfile write port, the CSR port, exception/ertn flush and ecode. Retired-instruction trace records go into a TRACE_DEPTH FIFO with a valid/ready debug port; when that FIFO is full, the stage back-pressures MEM.

Parameters:
XLEN, 32, datapath/PC width
RADDR_W, 5, regfile address width
CSR_NUM_W, 14, CSR number width
ECODE_W, 6, exception code width
ESUB_W, 9, exception subcode width
TRACE_DEPTH, 4, trace FIFO entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
mem_valid  in  1  MEM presents an instruction
wb_allowin  out  1  stage accepts this cycle
mem_pc  in  XLEN  instruction PC
mem_gr_we  in  1  writes GPR
mem_dest  in  RADDR_W  destination GPR
mem_result  in  XLEN  ALU/load result
mem_csr_re  in  1  result comes from CSR read
mem_csr_we  in  1  CSR write
mem_csr_num  in  CSR_NUM_W  CSR number
mem_csr_wmask  in  XLEN  CSR write mask
mem_csr_wvalue  in  XLEN  CSR write data
mem_ex  in  1  instruction carries exception
mem_ecode  in  ECODE_W  ecode
mem_esubcode  in  ESUB_W  esubcode
mem_ertn  in  1  ertn instruction
csr_re  out  1  CSR read enable
csr_num  out  CSR_NUM_W  CSR number
csr_rvalue  in  XLEN  CSR read data (combinational)
csr_we  out  1  CSR write strobe
csr_wmask  out  XLEN  CSR mask
csr_wvalue  out  XLEN  CSR data
wb_ex  out  1  exception commit pulse
ertn_flush  out  1  ertn commit pulse
wb_pc  out  XLEN  PC of WB instruction
wb_ecode  out  ECODE_W  ecode
wb_esubcode  out  ESUB_W  esubcode
rf_we  out  1  regfile write
rf_waddr  out  RADDR_W  regfile address
rf_wdata  out  XLEN  regfile data
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_pc  out  XLEN  retired PC
trace_we  out  4  byte write enables, all equal rf_we
trace_waddr  out  RADDR_W  retired dest
trace_wdata  out  XLEN  retired data

Behaviour:
- Reset (async, rst=1): wb_valid=0, FIFO empty (count=0, pointers 0). Consequences: trace_valid=0, wb_allowin=1, all strobes (rf_we, csr_we, csr_re, wb_ex, ertn_flush) =0. All payload registers clear to 0.
- State: 1-entry WB register (wb_valid plus payload), and a trace FIFO with count width $clog2(TRACE_DEPTH+1).
- fifo_can_push = (count<TRACE_DEPTH) | trace_ready.
- ready_go = ~needs_trace | fifo_can_push, where needs_trace = ~ex.
- commit = wb_valid & ready_go.
- wb_allowin = ~wb_valid | ready_go.
- Load: mem_valid & wb_allowin captures the payload next edge. If commit occurs with no load, wb_valid goes to 0.
- Flush: commit & (ex|ertn) forces wb_valid<=0 next edge, and any simultaneously offered MEM instruction is dropped.
- Combinational outputs from the WB register:
  - csr_re = wb_valid & csr_re_r; csr_num = csr_num_r.
  - rf_wdata = csr_re_r ? csr_rvalue : result_r.
  - rf_we = commit & gr_we_r & ~ex_r.
  - csr_we = commit & csr_we_r & ~ex_r.
  - wb_ex = commit & ex_r.
  - ertn_flush = commit & ertn_r & ~ex_r.
  - wb_pc, wb_ecode, wb_esubcode are driven direct from the register.
- Each strobe is high exactly one cycle per committed instruction. The WB register holds across stalls without repeating strobes.
- Trace push: commit & ~ex_r writes {pc, rf_we, dest, rf_wdata}. ertn pushes with trace_we=0. Exceptions push nothing.
- Pop: trace_valid & trace_ready.
- Simultaneous push+pop: count unchanged, legal even when full.
- Pointers wrap modulo TRACE_DEPTH.
- FIFO head outputs are registered storage, not a bypass. A push appears on trace_valid the cycle after it is written.
- Reset mid-stall discards the WB instruction and all FIFO contents.

Decomposition:
- Shared package holds the constants XLEN, RADDR_W, CSR_NUM_W, ECODE_W and ESUB_W.
- Shared package holds the trace record field layout and its total width.
- One sub-module: trace_fifo (parametrised width/depth, sync FIFO, async reset), which provides count/full/empty.

Test Plan:
- Reset then idle, with rst pulsed asynchronously mid-cycle -> wb_allowin=1, trace_valid=0, all strobes 0 immediately.
- Load add r5=0x1234 at pc 0x1c000000, trace_ready=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. One cycle later trace_valid=1 with trace_pc=0x1c000000 and trace_we=4'hf.
- csrrd of CSR 0x6 with csr_rvalue=0xABCD -> rf_wdata=0xABCD, csr_re=1, trace_wdata=0xABCD.
- Syscall (ex=1, ecode=0xB) with the next instruction offered simultaneously -> wb_ex one-cycle pulse, rf_we=0, no trace push, next instruction dropped (wb_valid=0).
- trace_ready=0 with 4 retiring instructions -> count=4. The 5th instruction stalls: wb_allowin=0, no rf_we, no duplicate strobe. Raising trace_ready -> 5th instruction commits in that same cycle with count staying 4.
- ertn with csr_we=1 -> ertn_flush pulse, csr_we pulse, trace entry with trace_we=0.
